snitch_dmem_responder: RTL and testbench

- Memory-side responder for the Snitch core data interface.
- Accepts dreq_t requests: load, store with byte strobes, and AMO.
- Serves them from a local flop-based word array and returns dresp_t responses carrying the request id.
- Sits at the end of a core data port in standalone tests and small clusters, as the counterpart of the core's load/store unit.

---
 rtl/snitch_dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_snitch_dmem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_dmem_responder.sv
// Memory-side responder for the Snitch core data port: a flop-based word array
// serving loads, strobed stores and AMOs, with an in-order response FIFO.
package snitch_dmem_pkg;
    localparam int unsigned MetaIdWidth = 3;

    typedef struct packed {
        logic [31:0]            addr;
        logic [MetaIdWidth-1:0] id;
        logic [3:0]             amo;
        logic                   write;
        logic [31:0]            data;
        logic [3:0]             strb;
    } dreq_t;

    typedef struct packed {
        logic [31:0]            data;
        logic [MetaIdWidth-1:0] id;
        logic                   error;
    } dresp_t;
endpackage

module snitch_dmem_responder
    import snitch_dmem_pkg::*;
#(
    parameter int unsigned NumWords  = 256,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000,
    parameter int unsigned RespDepth = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   q_valid_i,
    output logic   q_ready_o,
    input  dreq_t  data_req_i,
    output logic   p_valid_o,
    input  logic   p_ready_i,
    output dresp_t data_resp_o
);
    localparam int unsigned IdxW    = $clog2(NumWords);
    localparam int unsigned PtrW    = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW    = $clog2(RespDepth + 1);
    localparam logic [32:0] EndAddr = 33'(BaseAddr) + 33'(NumWords) * 33'd4;

    localparam logic [3:0] AmoSwap = 4'd1;
    localparam logic [3:0] AmoAdd  = 4'd2;
    localparam logic [3:0] AmoAnd  = 4'd3;
    localparam logic [3:0] AmoOr   = 4'd4;
    localparam logic [3:0] AmoXor  = 4'd5;
    localparam logic [3:0] AmoMax  = 4'd6;
    localparam logic [3:0] AmoMaxu = 4'd7;
    localparam logic [3:0] AmoMin  = 4'd8;
    localparam logic [3:0] AmoMinu = 4'd9;

    typedef enum logic {
        Idle,
        AmoWb
    } state_e;

    state_e state_q, state_d;

    logic [31:0]     mem_q [NumWords];
    dresp_t          fifo_q [RespDepth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic [3:0]      amo_op_q;
    logic [IdxW-1:0] amo_idx_q;
    logic [31:0]     amo_old_q, amo_operand_q;
    logic [31:0]     amo_result;

    logic            in_range, amo_illegal, fifo_full, idle_ready;
    logic            accept, pop, amo_start, store_en, amo_wb;
    logic [IdxW-1:0] req_idx;
    logic [31:0]     rdata;
    dresp_t          push_resp;

    function automatic logic [31:0] amo_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            AmoSwap: r = b;
            AmoAdd:  r = a + b;
            AmoAnd:  r = a & b;
            AmoOr:   r = a | b;
            AmoXor:  r = a ^ b;
            AmoMax:  r = ($signed(a) > $signed(b)) ? a : b;
            AmoMaxu: r = (a > b) ? a : b;
            AmoMin:  r = ($signed(a) < $signed(b)) ? a : b;
            AmoMinu: r = (a < b) ? a : b;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Request decode
    assign in_range    = ({1'b0, data_req_i.addr} >= 33'(BaseAddr)) &&
                         ({1'b0, data_req_i.addr} < EndAddr);
    assign amo_illegal = data_req_i.amo > AmoMinu;
    assign req_idx     = data_req_i.addr[2 +: IdxW];
    assign rdata       = mem_q[req_idx];

    assign fifo_full   = (cnt_q == CntW'(RespDepth));
    assign idle_ready  = !fifo_full || p_ready_i;
    assign accept      = q_valid_i && q_ready_o;
    assign pop         = p_valid_o && p_ready_i;
    assign p_valid_o   = (cnt_q != '0);
    assign data_resp_o = fifo_q[rd_ptr_q];
    assign amo_result  = amo_calc(amo_op_q, amo_old_q, amo_operand_q);

    // Response payload and operation select for the request on the port
    always_comb begin
        push_resp    = '0;
        push_resp.id = data_req_i.id;
        amo_start    = 1'b0;
        store_en     = 1'b0;
        if (!in_range || amo_illegal) begin
            push_resp.error = 1'b1;
        end else if (data_req_i.amo != 4'd0) begin
            push_resp.data = rdata;
            amo_start      = 1'b1;
        end else if (data_req_i.write) begin
            store_en = 1'b1;
        end else begin
            push_resp.data = rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= Idle;
        else         state_q <= state_d;
    end

    // AMO holds off new requests for one cycle while the result is written back
    always_comb begin
        state_d   = state_q;
        q_ready_o = 1'b0;
        amo_wb    = 1'b0;
        unique case (state_q)
            Idle: begin
                q_ready_o = idle_ready;
                if (q_valid_i && idle_ready && amo_start) state_d = AmoWb;
            end
            AmoWb: begin
                amo_wb  = 1'b1;
                state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            amo_op_q      <= '0;
            amo_idx_q     <= '0;
            amo_old_q     <= '0;
            amo_operand_q <= '0;
        end else if (accept && amo_start) begin
            amo_op_q      <= data_req_i.amo;
            amo_idx_q     <= req_idx;
            amo_old_q     <= rdata;
            amo_operand_q <= data_req_i.data;
        end
    end

    // Word array: AMO write-back and strobed store never coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumWords; i++) mem_q[i] <= '0;
        end else if (amo_wb) begin
            mem_q[amo_idx_q] <= amo_result;
        end else if (accept && store_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_req_i.strb[b]) mem_q[req_idx][8*b +: 8] <= data_req_i.data[8*b +: 8];
            end
        end
    end

    // Response FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RespDepth; i++) fifo_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= push_resp;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_snitch_dmem_responder.sv
// Scoreboard bench for snitch_dmem_responder: a reference memory model predicts each
// response at accept time; a monitor compares responses as they are popped.
module tb_snitch_dmem_responder;
    import snitch_dmem_pkg::*;

    localparam int unsigned NumWords  = 256;
    localparam logic [31:0] BaseAddr  = 32'h0000_0000;
    localparam int unsigned RespDepth = 2;

    logic   clk_i = 1'b0;
    logic   rst_ni;
    logic   q_valid_i;
    logic   q_ready_o;
    dreq_t  data_req_i;
    logic   p_valid_o;
    logic   p_ready_i;
    dresp_t data_resp_o;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    dresp_t      exp_q[$];
    logic [31:0] model_mem [NumWords];

    always #5 clk_i = ~clk_i;

    snitch_dmem_responder #(
        .NumWords (NumWords),
        .BaseAddr (BaseAddr),
        .RespDepth(RespDepth)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .q_valid_i  (q_valid_i),
        .q_ready_o  (q_ready_o),
        .data_req_i (data_req_i),
        .p_valid_o  (p_valid_o),
        .p_ready_i  (p_ready_i),
        .data_resp_o(data_resp_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] amo_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'd1:    return b;
            4'd2:    return a + b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return ($signed(a) >= $signed(b)) ? a : b;
            4'd7:    return (a >= b) ? a : b;
            4'd8:    return ($signed(a) <= $signed(b)) ? a : b;
            4'd9:    return (a <= b) ? a : b;
            default: return a;
        endcase
    endfunction

    // Predicts the response and applies the request's effect to the model memory
    function automatic dresp_t expect_resp(input dreq_t r);
        dresp_t      e;
        logic [31:0] off;
        int unsigned idx;
        logic [31:0] old;
        e    = '0;
        e.id = r.id;
        off  = r.addr - BaseAddr;
        idx  = int'(off >> 2);
        if (off >= 32'(NumWords * 4) || r.amo > 4'd9) begin
            e.error = 1'b1;
        end else begin
            old = model_mem[idx];
            if (r.amo != 4'd0) begin
                e.data         = old;
                model_mem[idx] = amo_model(r.amo, old, r.data);
            end else if (r.write) begin
                for (int b = 0; b < 4; b++)
                    if (r.strb[b]) model_mem[idx][8*b +: 8] = r.data[8*b +: 8];
            end else begin
                e.data = old;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a_addr, input logic [2:0] a_id, input logic [3:0] a_amo,
                         input logic a_write, input logic [31:0] a_data, input logic [3:0] a_strb);
        dreq_t r;
        bit    ok;
        ok      = 1'b0;
        r.addr  = a_addr;
        r.id    = a_id;
        r.amo   = a_amo;
        r.write = a_write;
        r.data  = a_data;
        r.strb  = a_strb;
        data_req_i = r;
        q_valid_i  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (q_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1 p_ready_i = 1'b1;
        end
        check("accept", 64'(ok), 64'd1);
        if (ok) exp_q.push_back(expect_resp(r));
        @(posedge clk_i);
        #1 q_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        p_ready_i = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk_i);
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: compare every popped response against the oldest prediction
    always @(negedge clk_i) begin
        dresp_t e;
        if (rst_ni && p_valid_o && p_ready_i) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("resp", 64'(data_resp_o), 64'(e));
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        rst_ni     = 1'b0;
        q_valid_i  = 1'b0;
        p_ready_i  = 1'b1;
        data_req_i = '0;
        for (int i = 0; i < int'(NumWords); i++) model_mem[i] = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_p_valid", 64'(p_valid_o), 64'd0);
        check("rst_resp", 64'(data_resp_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_q_ready", 64'(q_ready_o), 64'd1);
        @(posedge clk_i);
        #1;

        // First load after reset: response valid one cycle after accept
        issue(32'h10, 3'd3, 4'd0, 1'b0, 32'h0, 4'h0);
        check("lat_p_valid", 64'(p_valid_o), 64'd1);
        check("lat_q_ready", 64'(q_ready_o), 64'd1);

        // Strobed store then immediate load of the same word
        issue(32'h20, 3'd4, 4'd0, 1'b1, 32'hDEAD_BEEF, 4'b0101);
        issue(32'h20, 3'd5, 4'd0, 1'b0, 32'h0, 4'h0);
        check("model_strb", 64'(model_mem[8]), 64'h00AD_00EF);

        // AMO ADD / MIN on word 0x40
        issue(32'h40, 3'd0, 4'd0, 1'b1, 32'd5, 4'hF);
        issue(32'h40, 3'd1, 4'd2, 1'b0, 32'hFFFF_FFFE, 4'h0);
        check("amo_stall", 64'(q_ready_o), 64'd0);
        issue(32'h40, 3'd2, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h40, 3'd3, 4'd8, 1'b1, 32'h8000_0000, 4'h0);
        check("amo_stall_min", 64'(q_ready_o), 64'd0);
        issue(32'h40, 3'd4, 4'd0, 1'b0, 32'h0, 4'h0);

        // Error cases leave memory untouched
        issue(32'h0, 3'd5, 4'd0, 1'b1, 32'h1234_5678, 4'hF);
        issue(32'h400, 3'd6, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h0, 3'd7, 4'd12, 1'b0, 32'hFFFF_FFFF, 4'hF);
        check("amo_bad_no_stall", 64'(q_ready_o), 64'd1);
        issue(32'h404, 3'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 4'hF);
        issue(32'hFFFF_FFFC, 3'd1, 4'd1, 1'b0, 32'h0, 4'h0);
        issue(32'h3, 3'd2, 4'd0, 1'b0, 32'h0, 4'h0);

        // Every AMO code with random operands, each followed by a load
        for (int k = 1; k <= 9; k++) begin
            op = 4'(k);
            issue(32'h80, 3'(k), op, 1'b0, $urandom, 4'h0);
            issue(32'h82, 3'(k + 1), 4'd0, 1'b0, 32'h0, 4'h0);
        end
        wait_drain();

        // Backpressure: FIFO of two fills, ready drops, order preserved on release
        p_ready_i = 1'b0;
        issue(32'h00, 3'd0, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h20, 3'd1, 4'd0, 1'b0, 32'h0, 4'h0);
        data_req_i.addr = 32'h40;
        data_req_i.id   = 3'd2;
        data_req_i.amo  = 4'd0;
        data_req_i.write = 1'b0;
        q_valid_i       = 1'b1;
        @(negedge clk_i);
        check("bp_ready0", 64'(q_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("bp_ready1", 64'(q_ready_o), 64'd0);
        check("bp_valid", 64'(p_valid_o), 64'd1);
        check("bp_head_id", 64'(data_resp_o.id), 64'd0);
        @(posedge clk_i);
        #1 p_ready_i = 1'b1;
        issue(32'h40, 3'd2, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h80, 3'd3, 4'd0, 1'b0, 32'h0, 4'h0);
        wait_drain();

        // Random mixed traffic with random response backpressure
        for (int n = 0; n < 300; n++) begin
            p_ready_i = ($urandom_range(0, 3) != 0);
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 15) == 0) a = a + 32'h400;
            a = a | 32'($urandom_range(0, 3));
            op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            issue(a, 3'($urandom), op, 1'($urandom), $urandom, 4'($urandom));
        end
        wait_drain();

        // Reset with two responses queued and an AMO write-back pending
        issue(32'h50, 3'd0, 4'd0, 1'b1, 32'h0000_0007, 4'hF);
        issue(32'h60, 3'd1, 4'd0, 1'b1, 32'h0000_0009, 4'hF);
        wait_drain();
        p_ready_i = 1'b0;
        issue(32'h60, 3'd2, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h50, 3'd3, 4'd2, 1'b0, 32'h0000_0100, 4'h0);
        rst_ni = 1'b0;
        #1;
        check("midrst_p_valid", 64'(p_valid_o), 64'd0);
        check("midrst_resp", 64'(data_resp_o), 64'd0);
        exp_q.delete();
        for (int i = 0; i < int'(NumWords); i++) model_mem[i] = '0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        p_ready_i = 1'b1;
        issue(32'h50, 3'd4, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h60, 3'd5, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h20, 3'd6, 4'd0, 1'b0, 32'h0, 4'h0);
        issue(32'h40, 3'd7, 4'd0, 1'b0, 32'h0, 4'h0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
